// File: rtl/if_fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch pair in (f_*), head entry out (d_*).
// master = upstream fetch/decode environment, slave = the buffer itself.
interface if_fetch_buffer_if;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_ready;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic [31:0] d_instr;
  logic        d_exc_adel;

  modport master (
    output f_pc, f_instr, f_valid, d_ready,
    input  f_ready, d_valid, d_pc, d_pc8, d_instr, d_exc_adel
  );

  modport slave (
    input  f_pc, f_instr, f_valid, d_ready,
    output f_ready, d_valid, d_pc, d_pc8, d_instr, d_exc_adel
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch FIFO between PC/IM and decode; tags AdEL and precomputes pc+8.
// f_ready is a pure function of registered occupancy so it can drive the PC stall.
module if_fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  if_fetch_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  entry_t          mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [31:0]     stall_reg, stall_next;

  logic   push, pop, full, head_valid;
  logic   new_adel;
  entry_t new_entry;
  entry_t head_entry;

  assign full       = (count_reg >= CW'(DEPTH));
  assign head_valid = (count_reg != '0);
  assign push       = bus.f_valid & ~full & ~flush;
  assign pop        = head_valid & bus.d_ready & ~flush;

  // Entry fields are resolved at push time so decode sees a stable, final entry.
  assign new_adel = (bus.f_pc[1:0] != 2'b00) | (bus.f_pc < IM_BASE) | (bus.f_pc > IM_LIMIT);

  always_comb begin
    new_entry       = '0;
    new_entry.pc    = bus.f_pc;
    new_entry.pc8   = bus.f_pc + 32'd8;
    new_entry.instr = new_adel ? 32'h0 : bus.f_instr;
    new_entry.adel  = new_adel;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    stall_next  = stall_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
    // Stall accounting ignores flush: a redirect cycle with a blocked fetch still stalled.
    if (bus.f_valid && full) begin
      stall_next = stall_reg + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      stall_reg  <= '0;
    end else begin
      stall_reg <= stall_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        count_reg  <= count_next;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_reg[wr_ptr_reg] <= new_entry;
    end
  end

  assign head_entry = head_valid ? mem_reg[rd_ptr_reg] : '0;

  assign bus.f_ready    = ~full;
  assign bus.d_valid    = head_valid;
  assign bus.d_pc       = head_entry.pc;
  assign bus.d_pc8      = head_entry.pc8;
  assign bus.d_instr    = head_entry.instr;
  assign bus.d_exc_adel = head_entry.adel;
  assign count          = count_reg;
  assign stall_cycles   = stall_reg;
endmodule
